// File: rtl/sargantana_icache_mem_ctrl.sv
// Instruction-cache memory sequencer: arbitrates flush, refill and lookup
// traffic onto the single tag/data memory port, performs the hit compare,
// selects refill victims and walks all sets on flush.
module sargantana_icache_mem_ctrl #(
    parameter int unsigned ICACHE_N_WAY = 4,
    parameter int unsigned ICACHE_DEPTH = 64,
    parameter int unsigned ADDR_WIDHT   = 6,
    parameter int unsigned TAG_WIDHT    = 20,
    parameter int unsigned WAY_WIDHT    = 256
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    // fetch lookup
    input  logic                                   lkp_valid_i,
    output logic                                   lkp_ready_o,
    input  logic [ADDR_WIDHT-1:0]                  lkp_idx_i,
    input  logic [TAG_WIDHT-1:0]                   lkp_tag_i,
    output logic                                   rsp_valid_o,
    output logic                                   rsp_hit_o,
    output logic [ICACHE_N_WAY-1:0]                rsp_way_o,
    output logic [WAY_WIDHT-1:0]                   rsp_line_o,
    // L2 refill
    input  logic                                   fill_valid_i,
    output logic                                   fill_ready_o,
    input  logic [ADDR_WIDHT-1:0]                  fill_idx_i,
    input  logic [TAG_WIDHT-1:0]                   fill_tag_i,
    input  logic [WAY_WIDHT-1:0]                   fill_line_i,
    // flush
    input  logic                                   flush_req_i,
    output logic                                   flush_busy_o,
    output logic                                   flush_done_o,
    // tag/data memory port
    output logic [ICACHE_N_WAY-1:0]                mem_tag_req_o,
    output logic [ICACHE_N_WAY-1:0]                mem_data_req_o,
    output logic                                   mem_tag_we_o,
    output logic                                   mem_data_we_o,
    output logic                                   mem_flush_en_o,
    output logic                                   mem_valid_bit_o,
    output logic [TAG_WIDHT-1:0]                   mem_tag_o,
    output logic [WAY_WIDHT-1:0]                   mem_cline_o,
    output logic [ADDR_WIDHT-1:0]                  mem_addr_o,
    input  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] mem_tag_way_i,
    input  logic [ICACHE_N_WAY-1:0][WAY_WIDHT-1:0] mem_cline_way_i,
    input  logic [ICACHE_N_WAY-1:0]                mem_valid_bit_i
);

    localparam int unsigned WAY_IDX_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL_RD,
        FILL_WR,
        FLUSH
    } state_t;

    state_t                  state;
    logic [ADDR_WIDHT-1:0]   flush_cnt;
    logic [WAY_IDX_W-1:0]    rr_ptr;
    logic                    flush_pend;
    logic                    lkp_pend;
    logic                    flush_done_q;
    logic [TAG_WIDHT-1:0]    lkp_tag_q;

    logic                    flush_sel;
    logic                    lkp_grant;
    logic [WAY_IDX_W-1:0]    victim_idx;
    logic                    victim_found;
    logic [ICACHE_N_WAY-1:0] victim_oh;
    logic [ICACHE_N_WAY-1:0] hit_vec;
    logic [WAY_WIDHT-1:0]    hit_line;

    // A flush request raised in the same IDLE cycle as a refill must win,
    // so arbitration looks at the live request as well as the pending flag.
    assign flush_sel = (state == IDLE) && (flush_req_i || flush_pend);
    assign lkp_grant = !rst_i && (state == IDLE) && !flush_req_i && !flush_pend
                       && !fill_valid_i && lkp_valid_i;

    // Victim selection: lowest invalid way, else the round-robin pointer
    always_comb begin
        victim_idx   = rr_ptr;
        victim_found = 1'b0;
        for (int unsigned w = 0; w < ICACHE_N_WAY; w++) begin
            if (!victim_found && !mem_valid_bit_i[w]) begin
                victim_idx   = WAY_IDX_W'(w);
                victim_found = 1'b1;
            end
        end
        victim_oh             = '0;
        victim_oh[victim_idx] = 1'b1;
    end

    // Hit compare against the tag registered at lookup acceptance
    always_comb begin
        hit_vec  = '0;
        hit_line = '0;
        for (int unsigned w = 0; w < ICACHE_N_WAY; w++) begin
            if (lkp_pend && mem_valid_bit_i[w] && (mem_tag_way_i[w] == lkp_tag_q)) begin
                hit_vec[w] = 1'b1;
            end
            hit_line = hit_line | (mem_cline_way_i[w] & {WAY_WIDHT{hit_vec[w]}});
        end
    end

    assign rsp_valid_o    = lkp_pend;
    assign rsp_hit_o      = |hit_vec;
    assign rsp_way_o      = hit_vec;
    assign rsp_line_o     = hit_line;
    assign flush_busy_o   = flush_pend || (state == FLUSH);
    assign flush_done_o   = flush_done_q;
    assign mem_flush_en_o = 1'b0;

    // Sequencer state, flush walk counter, round-robin pointer and lookup tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            flush_cnt    <= '0;
            rr_ptr       <= '0;
            flush_pend   <= 1'b0;
            lkp_pend     <= 1'b0;
            flush_done_q <= 1'b0;
            lkp_tag_q    <= '0;
        end else begin
            flush_done_q <= 1'b0;
            lkp_pend     <= lkp_grant;
            if (lkp_grant) begin
                lkp_tag_q <= lkp_tag_i;
            end
            if (flush_req_i && (state != FLUSH)) begin
                flush_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (flush_sel) begin
                        state      <= FLUSH;
                        flush_pend <= 1'b0;
                        flush_cnt  <= '0;
                    end else if (fill_valid_i) begin
                        state <= FILL_RD;
                    end
                end
                FILL_RD: begin
                    state <= FILL_WR;
                end
                FILL_WR: begin
                    state <= IDLE;
                    if (!victim_found) begin
                        rr_ptr <= (rr_ptr == WAY_IDX_W'(ICACHE_N_WAY - 1)) ? '0 : rr_ptr + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == ADDR_WIDHT'(ICACHE_DEPTH - 1)) begin
                        flush_cnt    <= '0;
                        state        <= IDLE;
                        flush_done_q <= 1'b1;
                        rr_ptr       <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port and handshake drive for the granted requester
    always_comb begin
        lkp_ready_o     = 1'b0;
        fill_ready_o    = 1'b0;
        mem_tag_req_o   = '0;
        mem_data_req_o  = '0;
        mem_tag_we_o    = 1'b0;
        mem_data_we_o   = 1'b0;
        mem_valid_bit_o = 1'b0;
        mem_tag_o       = '0;
        mem_cline_o     = '0;
        mem_addr_o      = '0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (lkp_grant) begin
                        lkp_ready_o    = 1'b1;
                        mem_tag_req_o  = '1;
                        mem_data_req_o = '1;
                        mem_addr_o     = lkp_idx_i;
                    end
                end
                FILL_RD: begin
                    mem_tag_req_o = '1;
                    mem_addr_o    = fill_idx_i;
                end
                FILL_WR: begin
                    fill_ready_o    = 1'b1;
                    mem_tag_req_o   = victim_oh;
                    mem_data_req_o  = victim_oh;
                    mem_tag_we_o    = 1'b1;
                    mem_data_we_o   = 1'b1;
                    mem_valid_bit_o = 1'b1;
                    mem_tag_o       = fill_tag_i;
                    mem_cline_o     = fill_line_i;
                    mem_addr_o      = fill_idx_i;
                end
                FLUSH: begin
                    mem_tag_req_o   = '1;
                    mem_tag_we_o    = 1'b1;
                    mem_valid_bit_o = 1'b0;
                    mem_addr_o      = flush_cnt;
                end
                default: ;
            endcase
        end
    end

    // A valid line may live in at most one way of a set
    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(hit_vec));

endmodule

// File: doc/sargantana_icache_mem_ctrl.md
Name: sargantana_icache_mem_ctrl

Overview:
- Sequencer/arbiter for the instruction-cache tag+data memory array.
- Arbitrates three requesters for the single shared memory port: fetch lookups, L2 refills and flush. Priority is flush > refill > lookup.
- Performs the hit compare, chooses the refill victim way (first invalid way, else round-robin), and walks every set to invalidate on flush.
- Sits between the icache FSM/fetch front-end and the tag/data memory top.

Parameters:
ICACHE_N_WAY, 4, number of ways
ICACHE_DEPTH, 64, sets per way
ADDR_WIDHT, 6, set index width, equals clog2(ICACHE_DEPTH)
TAG_WIDHT, 20, tag width
WAY_WIDHT, 256, cache line width in bits

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
lkp_valid_i  in  1  lookup request
lkp_ready_o  out  1  lookup accepted this cycle
lkp_idx_i  in  ADDR_WIDHT  lookup set index
lkp_tag_i  in  TAG_WIDHT  lookup tag
rsp_valid_o  out  1  lookup result valid
rsp_hit_o  out  1  hit
rsp_way_o  out  ICACHE_N_WAY  one-hot hit way, 0 on miss
rsp_line_o  out  WAY_WIDHT  hit line, 0 on miss
fill_valid_i  in  1  refill request; fill inputs held stable until fill_ready_o
fill_ready_o  out  1  refill write performed this cycle
fill_idx_i  in  ADDR_WIDHT  refill set
fill_tag_i  in  TAG_WIDHT  refill tag
fill_line_i  in  WAY_WIDHT  refill line
flush_req_i  in  1  flush request (pulse or level)
flush_busy_o  out  1  flush pending or in progress
flush_done_o  out  1  one-cycle pulse at flush completion
mem_tag_req_o  out  ICACHE_N_WAY  per-way tag enable
mem_data_req_o  out  ICACHE_N_WAY  per-way data enable
mem_tag_we_o / mem_data_we_o  out  1 each  write enables
mem_flush_en_o  out  1  tied 0
mem_valid_bit_o  out  1  valid bit to write
mem_tag_o  out  TAG_WIDHT  tag to write
mem_cline_o  out  WAY_WIDHT  line to write
mem_addr_o  out  ADDR_WIDHT  set address
mem_tag_way_i  in  ICACHE_N_WAY x TAG_WIDHT  tags read, 1-cycle read latency
mem_cline_way_i  in  ICACHE_N_WAY x WAY_WIDHT  lines read
mem_valid_bit_i  in  ICACHE_N_WAY  valid bits read

Behaviour:
- States: IDLE, FILL_RD, FILL_WR, FLUSH.
- Reset:
  - State = IDLE; flush counter, round-robin pointer rr_ptr, flush_pend, lkp_pend and the registered lookup tag all cleared.
  - All outputs are 0.
  - Reset during FLUSH aborts the walk; flush_done_o does not pulse.
- flush_pend:
  - Set by flush_req_i in any state.
  - Cleared on entry to FLUSH.
  - A request arriving during FLUSH is merged: no second walk.
  - flush_busy_o = flush_pend | (state==FLUSH).
- IDLE arbitration:
  - flush_pend → FLUSH.
  - Else fill_valid_i → FILL_RD.
  - Else lkp_ready_o = lkp_valid_i. On acceptance: mem_tag_req_o = mem_data_req_o = all ones, write enables 0, mem_addr_o = lkp_idx_i; lkp_tag_i is registered and lkp_pend is set.
- Lookup response (cycle after acceptance):
  - rsp_valid_o = 1.
  - Hit vector = per way (mem_valid_bit_i & mem_tag_way_i == registered tag).
  - rsp_hit_o = OR of hit vector; rsp_way_o = hit vector; rsp_line_o = AND-OR mux of mem_cline_way_i.
  - Multiple hits are illegal; an SVA assertion checks at most one bit is set.
  - Back-to-back lookups give one response per cycle.
  - The response is produced even if the state changes in the same cycle.
- FILL_RD (1 cycle): tag read of all ways at fill_idx_i → FILL_WR.
- FILL_WR (1 cycle):
  - Victim = lowest-index way with mem_valid_bit_i==0; if all ways are valid, victim = rr_ptr and rr_ptr increments modulo ICACHE_N_WAY.
  - Drive mem_tag_req_o = mem_data_req_o = onehot(victim), both write enables 1, mem_valid_bit_o = 1, mem_tag_o = fill_tag_i, mem_cline_o = fill_line_i, mem_addr_o = fill_idx_i.
  - fill_ready_o = 1. Next state IDLE.
  - A flush requested during a refill waits for FILL_WR to complete.
- FLUSH (ICACHE_DEPTH cycles):
  - For cnt = 0..ICACHE_DEPTH-1: mem_tag_req_o all ones, mem_tag_we_o = 1, mem_valid_bit_o = 0, mem_addr_o = cnt. Data memory is not accessed.
  - After cnt = ICACHE_DEPTH-1, cnt wraps to 0 and the state returns to IDLE.
  - flush_done_o pulses in the first IDLE cycle; rr_ptr is cleared.
- Lookups and refills are stalled (ready = 0) in every state except IDLE.
- Memory outputs are 0 in idle cycles with no grant.

Test Plan:
- Reset, then FLUSH with DEPTH=64 → mem_addr_o walks 0..63 over 64 consecutive cycles with tag_we=1, valid=0; flush_done_o pulses at cycle 65; flush_busy_o is 0 afterwards.
- Refill idx=5, tag=0xABCDE into an empty set → victim way0 (req=4'b0001, both we=1); lookup idx=5 tag=0xABCDE → rsp_hit_o=1, rsp_way_o=4'b0001, rsp_line_o = refill line.
- Five refills to idx=3 with distinct tags → ways 0,1,2,3, then way0 again (rr_ptr); lookup of the first tag → miss, rsp_way_o=0.
- flush_req_i and fill_valid_i asserted in the same IDLE cycle → FLUSH runs first, then the refill; lkp_ready_o stays 0 throughout.
- 8 back-to-back lookups → 8 consecutive rsp_valid_o cycles with correct hit/miss results; flush_req_i pulsed mid-stream → lkp_ready_o drops on the next IDLE arbitration.
- rst_i asserted at flush cnt=20 → all outputs 0 the next cycle, no flush_done_o pulse, state IDLE.
